multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Control FSM for a multicycle MIPS-subset datapath. Sequences
//            fetch, decode, execute, memory and write-back steps. Waits on
//            memory with a bounded wait counter. Traps illegal opcodes,
//            memory timeouts and corrupt state encodings into a sticky ERR
//            state. Counts retired instructions.
// Ports    : clk, start_up (async active-high reset)
//            opcode[5:0], zero, msb, mem_ack        -- status inputs
//            mem_req, mem_wr, i_or_d                -- memory access control
//            ir_wr, pc_wr, reg_wr, reg_dst, ext_op,
//            mem_to_reg, alu_src_a                  -- datapath enables/selects
//            pc_src[1:0], alu_src_b[1:0], alu_op[1:0]
//            state[3:0], err_code[1:0], instr_count[15:0]
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        start_up,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        msb,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        i_or_d,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        reg_wr,
  output logic        reg_dst,
  output logic        ext_op,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [3:0]  state,
  output logic [1:0]  err_code,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_REX  = 4'd2,
    S_IEX  = 4'd3,
    S_MADR = 4'd4,
    S_MRD  = 4'd5,
    S_MWR  = 4'd6,
    S_WBA  = 4'd7,
    S_WBM  = 4'd8,
    S_BR   = 4'd9,
    S_JMP  = 4'd10,
    S_ERR  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_STATE   = 2'b11;

  // Last wait count at which a missing ack is still tolerated.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] instr_count_q, instr_count_d;

  logic        in_wait;
  logic        wait_hit;

  assign in_wait  = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
  assign wait_hit = (wait_q == WAIT_LAST);

  // Next state and outputs. All outputs are held at 0 while start_up is
  // asserted so nothing leaks out of the datapath during reset.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    i_or_d     = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    ext_op     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;

    if (!start_up) begin
      case (state_q)
        S_IF: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          // An ack on the final allowed wait cycle still wins over timeout.
          if (mem_ack) begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = S_ID;
          end else if (wait_hit) begin
            state_d = S_ERR;
            err_d   = ERR_TIMEOUT;
          end
        end
        S_ID: begin
          alu_src_b = 2'b11;
          ext_op    = 1'b1;
          case (opcode)
            OP_RTYPE:         state_d = S_REX;
            OP_ADDI, OP_ORI:  state_d = S_IEX;
            OP_LW, OP_SW:     state_d = S_MADR;
            OP_BEQ, OP_BGTZ:  state_d = S_BR;
            OP_J:             state_d = S_JMP;
            default: begin
              state_d = S_ERR;
              err_d   = ERR_OPCODE;
            end
          endcase
        end
        S_REX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_WBA;
        end
        S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (opcode == OP_ORI) begin
            alu_op = 2'b11;
          end else begin
            ext_op = 1'b1;
          end
          state_d = S_WBA;
        end
        S_WBA: begin
          reg_wr  = 1'b1;
          reg_dst = (opcode == OP_RTYPE);
          state_d = S_IF;
        end
        S_MADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
          state_d   = (opcode == OP_LW) ? S_MRD : S_MWR;
        end
        S_MRD, S_MWR: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          mem_wr  = (state_q == S_MWR);
          if (mem_ack) begin
            state_d = (state_q == S_MRD) ? S_WBM : S_IF;
          end else if (wait_hit) begin
            state_d = S_ERR;
            err_d   = ERR_TIMEOUT;
          end
        end
        S_WBM: begin
          reg_wr     = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_IF;
        end
        S_BR: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          // bgtz: taken only when the difference is strictly positive.
          pc_wr     = (opcode == OP_BEQ) ? zero : (!zero && !msb);
          state_d   = S_IF;
        end
        S_JMP: begin
          pc_wr   = 1'b1;
          pc_src  = 2'b10;
          state_d = S_IF;
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          // Corrupt encoding (12..15): trap with a distinct code.
          state_d = S_ERR;
          err_d   = ERR_STATE;
        end
      endcase
    end
  end

  // Wait counter restarts on every state change and only advances while a
  // memory access is outstanding.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 4'd0;
    end else if (in_wait && !mem_ack) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // An instruction retires on the step that returns the FSM to fetch.
  always_comb begin
    instr_count_d = instr_count_q;
    if ((state_d == S_IF) &&
        ((state_q == S_WBA) || (state_q == S_WBM) || (state_q == S_MWR) ||
         (state_q == S_BR)  || (state_q == S_JMP))) begin
      instr_count_d = instr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge start_up) begin
    if (start_up) begin
      state_q       <= S_IF;
      wait_q        <= 4'd0;
      err_q         <= 2'b00;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      err_q         <= err_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign err_code    = err_q;
  assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control. Each task
//            walks one instruction or fault scenario cycle by cycle and
//            compares state plus a packed control word against hand-derived
//            values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic        clk;
  logic        start_up;
  logic [5:0]  opcode;
  logic        zero;
  logic        msb;
  logic        mem_ack;
  logic        mem_req, mem_wr, i_or_d, ir_wr, pc_wr, reg_wr, reg_dst;
  logic        ext_op, mem_to_reg, alu_src_a;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [1:0]  err_code;
  logic [15:0] instr_count;

  // Packed control word:
  // [15]mem_req [14]mem_wr [13]i_or_d [12]ir_wr [11]pc_wr [10]reg_wr
  // [9]reg_dst [8]ext_op [7]mem_to_reg [6]alu_src_a [5:4]pc_src
  // [3:2]alu_src_b [1:0]alu_op
  logic [15:0] ctl;
  assign ctl = {mem_req, mem_wr, i_or_d, ir_wr, pc_wr, reg_wr, reg_dst, ext_op,
                mem_to_reg, alu_src_a, pc_src, alu_src_b, alu_op};

  int n_pass;
  int n_total;
  logic [15:0] exp_count;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clk         (clk),
    .start_up    (start_up),
    .opcode      (opcode),
    .zero        (zero),
    .msb         (msb),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .i_or_d      (i_or_d),
    .ir_wr       (ir_wr),
    .pc_wr       (pc_wr),
    .reg_wr      (reg_wr),
    .reg_dst     (reg_dst),
    .ext_op      (ext_op),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .pc_src      (pc_src),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .state       (state),
    .err_code    (err_code),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    mem_ack = 1'b1;
    repeat (2) cyc();
    n_total++;
    if (state !== 4'd0) $display("FAIL reset_state got=%0d exp=0", state); else n_pass++;
    n_total++;
    if (err_code !== 2'b00) $display("FAIL reset_err got=%b exp=00", err_code); else n_pass++;
    n_total++;
    if (instr_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", instr_count); else n_pass++;
    n_total++;
    if (ctl !== 16'h0000) $display("FAIL reset_ctl got=%h exp=0000", ctl); else n_pass++;
    mem_ack  = 1'b0;
    start_up = 1'b0;
    #1;
    n_total++;
    if ({state, ctl} !== {4'd0, 16'h8004})
      $display("FAIL reset_release got state=%0d ctl=%h exp state=0 ctl=8004", state, ctl);
    else n_pass++;
    exp_count = 16'd0;
  endtask

  task automatic test_add;
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd2, 4'd7};
    logic [15:0] ec [4] = '{16'h9804, 16'h010C, 16'h0042, 16'h0600};
    opcode = 6'b000000; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if ({state, ctl} !== {es[i], ec[i]})
        $display("FAIL add_c%0d got state=%0d ctl=%h exp state=%0d ctl=%h", i, state, ctl, es[i], ec[i]);
      else n_pass++;
      cyc();
    end
    exp_count = exp_count + 16'd1;
    n_total++;
    if ({state, instr_count} !== {4'd0, exp_count})
      $display("FAIL add_retire got state=%0d count=%0d exp state=0 count=%0d", state, instr_count, exp_count);
    else n_pass++;
  endtask

  task automatic test_ori;
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd3, 4'd7};
    logic [15:0] ec [4] = '{16'h9804, 16'h010C, 16'h004B, 16'h0400};
    opcode = 6'b001101; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if ({state, ctl} !== {es[i], ec[i]})
        $display("FAIL ori_c%0d got state=%0d ctl=%h exp state=%0d ctl=%h", i, state, ctl, es[i], ec[i]);
      else n_pass++;
      cyc();
    end
    exp_count = exp_count + 16'd1;
    n_total++;
    if ({state, instr_count} !== {4'd0, exp_count})
      $display("FAIL ori_retire got state=%0d count=%0d exp state=0 count=%0d", state, instr_count, exp_count);
    else n_pass++;
  endtask

  // lw with three wait cycles in both IF and MRD; ack is also driven high in
  // ID, MADR and WBM, where it must have no effect.
  task automatic test_lw_wait;
    logic [3:0]  es [11] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd8};
    logic [15:0] ec [11] = '{16'h8004, 16'h8004, 16'h8004, 16'h9804, 16'h010C, 16'h0148,
                             16'hA000, 16'hA000, 16'hA000, 16'hA000, 16'h0480};
    int wb_hits = 0;
    opcode = 6'b100011;
    for (int c = 0; c < 11; c++) begin
      mem_ack = !((c <= 2) || (c >= 6 && c <= 8));
      #1;
      n_total++;
      if ({state, ctl} !== {es[c], ec[c]})
        $display("FAIL lw_c%0d got state=%0d ctl=%h exp state=%0d ctl=%h", c, state, ctl, es[c], ec[c]);
      else n_pass++;
      if (reg_wr && mem_to_reg) wb_hits++;
      cyc();
    end
    exp_count = exp_count + 16'd1;
    n_total++;
    if ({state, instr_count} !== {4'd0, exp_count})
      $display("FAIL lw_retire got state=%0d count=%0d exp state=0 count=%0d", state, instr_count, exp_count);
    else n_pass++;
    n_total++;
    if (wb_hits !== 1) $display("FAIL lw_wb_once got=%0d exp=1", wb_hits); else n_pass++;
  endtask

  task automatic test_sw;
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd4, 4'd6};
    logic [15:0] ec [4] = '{16'h9804, 16'h010C, 16'h0148, 16'hE000};
    opcode = 6'b101011; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if ({state, ctl} !== {es[i], ec[i]})
        $display("FAIL sw_c%0d got state=%0d ctl=%h exp state=%0d ctl=%h", i, state, ctl, es[i], ec[i]);
      else n_pass++;
      cyc();
    end
    exp_count = exp_count + 16'd1;
    n_total++;
    if ({state, instr_count} !== {4'd0, exp_count})
      $display("FAIL sw_retire got state=%0d count=%0d exp state=0 count=%0d", state, instr_count, exp_count);
    else n_pass++;
  endtask

  task automatic test_branch;
    logic [5:0]  op  [5] = '{6'b000100, 6'b000100, 6'b000111, 6'b000111, 6'b000111};
    logic        zv  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        mv  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] ebr [5] = '{16'h0851, 16'h0051, 16'h0051, 16'h0851, 16'h0051};
    for (int k = 0; k < 5; k++) begin
      opcode = op[k]; zero = zv[k]; msb = mv[k]; mem_ack = 1'b1;
      cyc();
      cyc();
      n_total++;
      if ({state, ctl} !== {4'd9, ebr[k]})
        $display("FAIL br_case%0d got state=%0d ctl=%h exp state=9 ctl=%h", k, state, ctl, ebr[k]);
      else n_pass++;
      cyc();
      exp_count = exp_count + 16'd1;
      n_total++;
      if ({state, instr_count} !== {4'd0, exp_count})
        $display("FAIL br_retire%0d got state=%0d count=%0d exp state=0 count=%0d", k, state, instr_count, exp_count);
      else n_pass++;
    end
    zero = 1'b0; msb = 1'b0;
  endtask

  task automatic test_jump;
    logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd10};
    logic [15:0] ec [3] = '{16'h9804, 16'h010C, 16'h0820};
    opcode = 6'b000010; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if ({state, ctl} !== {es[i], ec[i]})
        $display("FAIL j_c%0d got state=%0d ctl=%h exp state=%0d ctl=%h", i, state, ctl, es[i], ec[i]);
      else n_pass++;
      cyc();
    end
    exp_count = exp_count + 16'd1;
    n_total++;
    if ({state, instr_count} !== {4'd0, exp_count})
      $display("FAIL j_retire got state=%0d count=%0d exp state=0 count=%0d", state, instr_count, exp_count);
    else n_pass++;
  endtask

  // Preload the retired count to its top value, then retire one jump.
  task automatic test_wrap;
    force dut.instr_count_q = 16'hFFFF;
    #1;
    release dut.instr_count_q;
    #1;
    n_total++;
    if (instr_count !== 16'hFFFF) $display("FAIL wrap_preload got=%h exp=ffff", instr_count); else n_pass++;
    opcode = 6'b000010; mem_ack = 1'b1;
    repeat (3) cyc();
    exp_count = 16'h0000;
    n_total++;
    if ({state, instr_count} !== {4'd0, exp_count})
      $display("FAIL wrap_count got state=%0d count=%h exp state=0 count=0000", state, instr_count);
    else n_pass++;
  endtask

  task automatic test_startup_mwr;
    opcode = 6'b101011; mem_ack = 1'b1;
    repeat (3) cyc();
    mem_ack = 1'b0;
    #1;
    n_total++;
    if ({state, ctl} !== {4'd6, 16'hE000})
      $display("FAIL mwr_wait got state=%0d ctl=%h exp state=6 ctl=e000", state, ctl);
    else n_pass++;
    #1;
    start_up = 1'b1;
    #1;
    n_total++;
    if ({state, ctl, instr_count} !== {4'd0, 16'h0000, 16'h0000})
      $display("FAIL mwr_async_rst got state=%0d ctl=%h count=%0d exp state=0 ctl=0000 count=0", state, ctl, instr_count);
    else n_pass++;
    cyc();
    start_up = 1'b0;
    exp_count = 16'd0;
    #1;
    n_total++;
    if ({state, ctl} !== {4'd0, 16'h8004})
      $display("FAIL mwr_refetch got state=%0d ctl=%h exp state=0 ctl=8004", state, ctl);
    else n_pass++;
  endtask

  // Ack arrives on the last tolerated wait cycle (wait count 14).
  task automatic test_timeout_edge;
    int bad = 0;
    start_up = 1'b1; #1; start_up = 1'b0;
    opcode = 6'b000010; mem_ack = 1'b0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (state !== 4'd0) bad++;
      cyc();
    end
    n_total++;
    if (bad !== 0) $display("FAIL tmo_edge_hold got bad=%0d exp=0", bad); else n_pass++;
    mem_ack = 1'b1;
    #1;
    n_total++;
    if ({state, ctl} !== {4'd0, 16'h9804})
      $display("FAIL tmo_edge_ack got state=%0d ctl=%h exp state=0 ctl=9804", state, ctl);
    else n_pass++;
    cyc();
    n_total++;
    if ({state, err_code} !== {4'd1, 2'b00})
      $display("FAIL tmo_edge_id got state=%0d err=%b exp state=1 err=00", state, err_code);
    else n_pass++;
    repeat (2) cyc();
  endtask

  task automatic test_timeout;
    int bad = 0;
    start_up = 1'b1; #1; start_up = 1'b0;
    exp_count = 16'd0;
    mem_ack = 1'b0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (state !== 4'd0) bad++;
      cyc();
    end
    n_total++;
    if (bad !== 0) $display("FAIL tmo_if_hold got bad=%0d exp=0", bad); else n_pass++;
    n_total++;
    if ({state, err_code, ctl} !== {4'd11, 2'b10, 16'h0000})
      $display("FAIL tmo_err got state=%0d err=%b ctl=%h exp state=11 err=10 ctl=0000", state, err_code, ctl);
    else n_pass++;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ack = c[0];
      opcode  = 6'(c);
      #1;
      if ({state, err_code, ctl} !== {4'd11, 2'b10, 16'h0000}) bad++;
      cyc();
    end
    n_total++;
    if (bad !== 0) $display("FAIL tmo_sticky got bad=%0d exp=0", bad); else n_pass++;
    start_up = 1'b1;
    #1;
    n_total++;
    if ({state, err_code} !== {4'd0, 2'b00})
      $display("FAIL tmo_reset got state=%0d err=%b exp state=0 err=00", state, err_code);
    else n_pass++;
    start_up = 1'b0;
  endtask

  task automatic test_illegal;
    opcode = 6'b111111; mem_ack = 1'b1;
    cyc();
    #1;
    n_total++;
    if ({state, ctl} !== {4'd1, 16'h010C})
      $display("FAIL ill_id got state=%0d ctl=%h exp state=1 ctl=010c", state, ctl);
    else n_pass++;
    cyc();
    repeat (3) cyc();
    n_total++;
    if ({state, err_code, ctl, instr_count} !== {4'd11, 2'b01, 16'h0000, 16'h0000})
      $display("FAIL ill_err got state=%0d err=%b ctl=%h count=%0d exp state=11 err=01 ctl=0000 count=0",
               state, err_code, ctl, instr_count);
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    exp_count = 16'd0;
    start_up  = 1'b1;
    opcode    = 6'd0;
    zero      = 1'b0;
    msb       = 1'b0;
    mem_ack   = 1'b0;
    test_reset();
    test_add();
    test_ori();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_wrap();
    test_startup_mwr();
    test_timeout_edge();
    test_timeout();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
